gray_frame_seq: RTL and testbench

//  Frame sequencer between the grayscale stage's output FIFO and the sobel input FIFO.
//  On start, moves exactly WIDTH*HEIGHT pixels, tracks column/row, and tags each pixel

---
 rtl/gray_frame_seq_pkg.sv | 24 ++
 rtl/gray_frame_seq_pixel_xy_counter.sv | 52 +++++
 rtl/gray_frame_seq.sv | 109 ++++++++++
 tb/tb_gray_frame_seq.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_frame_seq_pkg.sv
// gray_frame_seq_pkg
//   Shared definitions for the grayscale->sobel frame sequencer:
//   FSM state encoding (3 bits, IDLE=0 .. ABORTED=4) and the positions
//   of the end-of-line / end-of-frame tag bits above the pixel byte.
package gray_frame_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_DONE    = 3'd3,
    ST_ABORTED = 3'd4
  } seq_state_t;

  // Tag bits sit directly above the pixel: {eof, eol, pixel}.
  function automatic int unsigned eol_bit(input int unsigned dwidth);
    return dwidth;
  endfunction

  function automatic int unsigned eof_bit(input int unsigned dwidth);
    return dwidth + 1;
  endfunction

endpackage

// File: rtl/gray_frame_seq_pixel_xy_counter.sv
// pixel_xy_counter
//   Column/row position of the next pixel in a WIDTH x HEIGHT frame.
//   Ports:
//     clock, reset   rising-edge clock, async active-low reset
//     inc            advance one pixel (col wraps and bumps row; last pixel
//                    clears both)
//     clr            force col=row=0 (priority over inc)
//     col, row       current position
//     last_col       col == WIDTH-1
//     last_pix       last column of the last row
module pixel_xy_counter #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540,
  localparam int CW = $clog2(WIDTH),
  localparam int RW = $clog2(HEIGHT)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last_col,
  output logic          last_pix
);

  always_comb begin
    last_col = (col == CW'(WIDTH - 1));
    last_pix = last_col && (row == RW'(HEIGHT - 1));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      if (last_pix) begin
        col <= '0;
        row <= '0;
      end else if (last_col) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/gray_frame_seq.sv
// gray_frame_seq
//   Moves exactly WIDTH*HEIGHT pixels from the grayscale output FIFO (FWFT)
//   to the sobel input FIFO, tagging each with {eof, eol}. An abort drains
//   the rest of the frame from the input FIFO so the stream stays aligned.
//   Ports:
//     clock, reset      rising-edge clock, async active-low reset
//     start, abort      1-cycle control pulses
//     busy              registered, high in RUN or FLUSH
//     frame_done        registered pulse after the last pixel is written
//     frame_aborted     registered pulse after the flush finishes
//     col, row          position of the next pixel
//     fifo_in_*         input FIFO (read strobe is combinational)
//     fifo_out_*        output FIFO (write strobe is combinational)
module gray_frame_seq
  import gray_frame_seq_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540,
  localparam int CW = $clog2(WIDTH),
  localparam int RW = $clog2(HEIGHT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_aborted,
  output logic [CW-1:0]     col,
  output logic [RW-1:0]     row,
  output logic              fifo_in_rd_en,
  input  logic [DWIDTH-1:0] fifo_in_dout,
  input  logic              fifo_in_empty,
  output logic              fifo_out_wr_en,
  output logic [DWIDTH+1:0] fifo_out_din,
  input  logic              fifo_out_full
);

  localparam int unsigned EOL_BIT = eol_bit(DWIDTH);
  localparam int unsigned EOF_BIT = eof_bit(DWIDTH);

  seq_state_t state, state_nxt;
  logic       xfer;
  logic       last_col;
  logic       last_pix;

  pixel_xy_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_xy (
    .clock   (clock),
    .reset   (reset),
    .inc     (fifo_in_rd_en),
    .clr     (state == ST_IDLE),
    .col     (col),
    .row     (row),
    .last_col(last_col),
    .last_pix(last_pix)
  );

  // Strobes: in RUN a pixel moves only when both sides are ready; in FLUSH
  // pixels are read and dropped.
  always_comb begin
    xfer           = (state == ST_RUN) && !fifo_in_empty && !fifo_out_full;
    fifo_out_wr_en = xfer;
    fifo_in_rd_en  = xfer || ((state == ST_FLUSH) && !fifo_in_empty);
  end

  always_comb begin
    fifo_out_din               = '0;
    fifo_out_din[DWIDTH-1:0]   = fifo_in_dout;
    fifo_out_din[EOL_BIT]      = last_col;
    fifo_out_din[EOF_BIT]      = last_pix;
  end

  // A final transfer wins over a coincident abort.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (start && !abort) state_nxt = ST_RUN;
      ST_RUN: begin
        if (xfer && last_pix)  state_nxt = ST_DONE;
        else if (abort)        state_nxt = ST_FLUSH;
      end
      ST_FLUSH:   if (fifo_in_rd_en && last_pix) state_nxt = ST_ABORTED;
      ST_DONE:    state_nxt = ST_IDLE;
      ST_ABORTED: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // exactly with the state they report.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_aborted <= 1'b0;
    end else begin
      state         <= state_nxt;
      busy          <= (state_nxt == ST_RUN) || (state_nxt == ST_FLUSH);
      frame_done    <= (state_nxt == ST_DONE);
      frame_aborted <= (state_nxt == ST_ABORTED);
    end
  end

endmodule

// File: tb/tb_gray_frame_seq.sv
module tb_gray_frame_seq;

  localparam int DW   = 8;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       busy;
  logic       frame_done;
  logic       frame_aborted;
  logic [1:0] col;
  logic [1:0] row;
  logic       fifo_in_rd_en;
  logic [7:0] fifo_in_dout;
  logic       fifo_in_empty;
  logic       fifo_out_wr_en;
  logic [9:0] fifo_out_din;
  logic       fifo_out_full;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  gray_frame_seq #(
    .DWIDTH(DW),
    .WIDTH (W),
    .HEIGHT(H)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_aborted (frame_aborted),
    .col           (col),
    .row           (row),
    .fifo_in_rd_en (fifo_in_rd_en),
    .fifo_in_dout  (fifo_in_dout),
    .fifo_in_empty (fifo_in_empty),
    .fifo_out_wr_en(fifo_out_wr_en),
    .fifo_out_din  (fifo_out_din),
    .fifo_out_full (fifo_out_full)
  );

  // Expected tagged word for pixel i of a frame whose source bytes are A0+i.
  function automatic logic [9:0] exp_word(input int i);
    logic eol;
    logic eof;
    eol = ((i % W) == W - 1);
    eof = (i == NPIX - 1);
    return {eof, eol, 8'(8'hA0 + i)};
  endfunction

  // Issue a start pulse in IDLE with data available (no checks here).
  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1; abort = 1'b0; fifo_in_empty = 1'b0; fifo_out_full = 1'b0;
    fifo_in_dout = 8'hA0;
    @(negedge clock);
    start = 1'b0;
    #0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      fifo_in_empty = 1'($urandom);
      fifo_out_full = 1'($urandom);
      start = 1'($urandom);
      #1;
      n_cmp++;
      if ({fifo_in_rd_en, fifo_out_wr_en, busy, frame_done, frame_aborted} !== 5'b0 ||
          col !== 2'd0 || row !== 2'd0) begin
        n_err++;
        $display("FAIL reset_hold: rd=%b wr=%b busy=%b done=%b abt=%b col=%0d row=%0d, required all 0",
                 fifo_in_rd_en, fifo_out_wr_en, busy, frame_done, frame_aborted, col, row);
      end
    end
    @(negedge clock);
    reset = 1'b1; start = 1'b0; fifo_in_empty = 1'b0; fifo_out_full = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || fifo_in_rd_en !== 1'b0 || fifo_out_wr_en !== 1'b0) begin
        n_err++;
        $display("FAIL idle_after_reset: busy=%b rd=%b wr=%b, required 0 0 0",
                 busy, fifo_in_rd_en, fifo_out_wr_en);
      end
    end
  endtask

  task automatic test_normal_frame();
    int idx = 0;
    int busy_cnt = 0;
    int last_wr = -1;
    int done_at = -1;
    int done_cnt = 0;
    @(negedge clock);
    start = 1'b1; fifo_in_empty = 1'b0; fifo_out_full = 1'b0; fifo_in_dout = 8'hA0;
    #1;
    n_cmp++;
    if (fifo_in_rd_en !== 1'b0 || fifo_out_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL normal_start_cycle: rd=%b wr=%b, required 0 0", fifo_in_rd_en, fifo_out_wr_en);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      start = 1'b0;
      fifo_in_dout = 8'(8'hA0 + idx);
      #1;
      if (busy) busy_cnt++;
      if (frame_done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (fifo_out_wr_en) begin
        n_cmp++;
        if (idx >= NPIX || fifo_out_din !== exp_word(idx) || fifo_in_rd_en !== 1'b1) begin
          n_err++;
          $display("FAIL normal_word[%0d]: din=%h rd=%b, required din=%h rd=1",
                   idx, fifo_out_din, fifo_in_rd_en, exp_word(idx));
        end
        n_cmp++;
        if (col !== 2'(idx % W) || row !== 2'(idx / W)) begin
          n_err++;
          $display("FAIL normal_pos[%0d]: col=%0d row=%0d, required col=%0d row=%0d",
                   idx, col, row, idx % W, idx / W);
        end
        last_wr = c;
        idx++;
      end
    end
    n_cmp++;
    if (idx !== NPIX) begin
      n_err++;
      $display("FAIL normal_writes: got %0d, required %0d", idx, NPIX);
    end
    n_cmp++;
    if (done_cnt !== 1 || done_at !== last_wr + 1) begin
      n_err++;
      $display("FAIL normal_done: pulses=%0d at=%0d, required 1 pulse at %0d",
               done_cnt, done_at, last_wr + 1);
    end
    n_cmp++;
    if (busy_cnt !== NPIX) begin
      n_err++;
      $display("FAIL normal_busy_cycles: got %0d, required %0d", busy_cnt, NPIX);
    end
  endtask

  task automatic test_stall();
    int idx = 0;
    int done_cnt = 0;
    int strobe_err = 0;
    logic exp_wr;
    pulse_start();
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clock);
      fifo_in_empty = ((c % 2) == 1);
      fifo_out_full = ((c % 3) == 2);
      fifo_in_dout  = 8'(8'hA0 + idx);
      #1;
      if (frame_done) done_cnt++;
      exp_wr = (idx < NPIX) && !fifo_in_empty && !fifo_out_full;
      n_cmp++;
      if (fifo_out_wr_en !== exp_wr || fifo_in_rd_en !== exp_wr) begin
        n_err++;
        strobe_err++;
        if (strobe_err < 5)
          $display("FAIL stall_strobe c=%0d: wr=%b rd=%b, required %b %b",
                   c, fifo_out_wr_en, fifo_in_rd_en, exp_wr, exp_wr);
      end
      if (fifo_out_wr_en) begin
        n_cmp++;
        if (idx >= NPIX || fifo_out_din !== exp_word(idx)) begin
          n_err++;
          $display("FAIL stall_word[%0d]: din=%h, required %h", idx, fifo_out_din, exp_word(idx));
        end
        idx++;
      end
    end
    n_cmp++;
    if (idx !== NPIX || done_cnt !== 1) begin
      n_err++;
      $display("FAIL stall_frame: writes=%0d done_pulses=%0d, required %0d and 1", idx, done_cnt, NPIX);
    end
  endtask

  task automatic test_abort();
    int writes = 0;
    int discards = 0;
    int aborted_cnt = 0;
    int done_cnt = 0;
    int first_col = -1;
    int first_row = -1;
    logic aborted_seen = 1'b0;
    logic abort_sent = 1'b0;
    pulse_start();
    fifo_in_empty = 1'b0; fifo_out_full = 1'b0;
    for (int c = 0; c < 40 && !aborted_seen; c++) begin
      if (c > 0) @(negedge clock);
      if (writes == 5 && !abort_sent) begin
        abort = 1'b1; fifo_in_empty = 1'b1; abort_sent = 1'b1;
      end else begin
        abort = 1'b0; fifo_in_empty = 1'b0;
      end
      fifo_in_dout = 8'(8'hA0 + writes + discards);
      #1;
      if (frame_done) done_cnt++;
      if (frame_aborted) begin
        aborted_cnt++;
        aborted_seen = 1'b1;
        n_cmp++;
        if (col !== 2'd0 || row !== 2'd0 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL abort_pos_after: col=%0d row=%0d busy=%b, required 0 0 0", col, row, busy);
        end
      end
      if (fifo_out_wr_en) writes++;
      if (fifo_in_rd_en && !fifo_out_wr_en) begin
        discards++;
        n_cmp++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL abort_busy_flush: busy=%b, required 1", busy);
        end
      end
    end
    abort = 1'b0;
    n_cmp++;
    if (writes !== 5 || discards !== 7) begin
      n_err++;
      $display("FAIL abort_counts: writes=%0d discards=%0d, required 5 and 7", writes, discards);
    end
    n_cmp++;
    if (aborted_cnt !== 1 || done_cnt !== 0) begin
      n_err++;
      $display("FAIL abort_pulses: aborted=%0d done=%0d, required 1 and 0", aborted_cnt, done_cnt);
    end
    // Fresh frame after the abort.
    writes = 0; done_cnt = 0;
    pulse_start();
    for (int c = 0; c < 25; c++) begin
      if (c > 0) @(negedge clock);
      fifo_in_dout = 8'(8'hA0 + writes);
      #1;
      if (frame_done) done_cnt++;
      if (fifo_out_wr_en) begin
        if (writes == 0) begin
          first_col = int'(col);
          first_row = int'(row);
          n_cmp++;
          if (fifo_out_din !== exp_word(0)) begin
            n_err++;
            $display("FAIL abort_fresh_word0: din=%h, required %h", fifo_out_din, exp_word(0));
          end
        end
        writes++;
      end
    end
    n_cmp++;
    if (first_col !== 0 || first_row !== 0 || writes !== NPIX || done_cnt !== 1) begin
      n_err++;
      $display("FAIL abort_fresh_frame: col0=%0d row0=%0d writes=%0d done=%0d, required 0 0 %0d 1",
               first_col, first_row, writes, done_cnt, NPIX);
    end
  endtask

  task automatic test_ignored_controls();
    int idx = 0;
    int done_cnt = 0;
    int aborted_cnt = 0;
    // abort alone in IDLE
    @(negedge clock);
    abort = 1'b1; start = 1'b0; fifo_in_empty = 1'b0; fifo_out_full = 1'b0;
    @(negedge clock);
    abort = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || fifo_in_rd_en !== 1'b0 || frame_aborted !== 1'b0) begin
      n_err++;
      $display("FAIL abort_in_idle: busy=%b rd=%b abt=%b, required 0 0 0", busy, fifo_in_rd_en, frame_aborted);
    end
    // start together with abort in IDLE
    @(negedge clock);
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || fifo_in_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL start_abort_idle: busy=%b rd=%b, required 0 0", busy, fifo_in_rd_en);
    end
    // start mid-frame ignored; abort on the final transfer ignored
    pulse_start();
    for (int c = 0; c < 25; c++) begin
      if (c > 0) @(negedge clock);
      start = (idx == 3);
      abort = (idx == NPIX - 1);
      fifo_in_dout = 8'(8'hA0 + idx);
      #1;
      if (frame_done) done_cnt++;
      if (frame_aborted) aborted_cnt++;
      if (fifo_out_wr_en) begin
        n_cmp++;
        if (col !== 2'(idx % W) || row !== 2'(idx / W) || fifo_out_din !== exp_word(idx)) begin
          n_err++;
          $display("FAIL ignore_word[%0d]: col=%0d row=%0d din=%h, required %0d %0d %h",
                   idx, col, row, fifo_out_din, idx % W, idx / W, exp_word(idx));
        end
        idx++;
      end
    end
    start = 1'b0; abort = 1'b0;
    n_cmp++;
    if (idx !== NPIX || done_cnt !== 1 || aborted_cnt !== 0) begin
      n_err++;
      $display("FAIL abort_on_last: writes=%0d done=%0d aborted=%0d, required %0d 1 0",
               idx, done_cnt, aborted_cnt, NPIX);
    end
  endtask

  task automatic test_reset_mid_frame();
    int idx = 0;
    int done_cnt = 0;
    pulse_start();
    for (int c = 0; c < 20 && idx < 6; c++) begin
      if (c > 0) @(negedge clock);
      fifo_in_dout = 8'(8'hA0 + idx);
      #1;
      if (fifo_out_wr_en) idx++;
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (fifo_in_rd_en !== 1'b0 || fifo_out_wr_en !== 1'b0 || busy !== 1'b0 ||
        col !== 2'd0 || row !== 2'd0) begin
      n_err++;
      $display("FAIL reset_mid_drop: rd=%b wr=%b busy=%b col=%0d row=%0d, required all 0",
               fifo_in_rd_en, fifo_out_wr_en, busy, col, row);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      n_cmp++;
      if (frame_done !== 1'b0 || frame_aborted !== 1'b0 || busy !== 1'b0 || fifo_in_rd_en !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid_idle: done=%b abt=%b busy=%b rd=%b, required 0 0 0 0",
                 frame_done, frame_aborted, busy, fifo_in_rd_en);
      end
    end
    idx = 0;
    pulse_start();
    for (int c = 0; c < 25; c++) begin
      if (c > 0) @(negedge clock);
      fifo_in_dout = 8'(8'hA0 + idx);
      #1;
      if (frame_done) done_cnt++;
      if (fifo_out_wr_en) begin
        n_cmp++;
        if (col !== 2'(idx % W) || row !== 2'(idx / W) || fifo_out_din !== exp_word(idx)) begin
          n_err++;
          $display("FAIL reset_next_word[%0d]: col=%0d row=%0d din=%h, required %0d %0d %h",
                   idx, col, row, fifo_out_din, idx % W, idx / W, exp_word(idx));
        end
        idx++;
      end
    end
    n_cmp++;
    if (idx !== NPIX || done_cnt !== 1) begin
      n_err++;
      $display("FAIL reset_next_frame: writes=%0d done=%0d, required %0d 1", idx, done_cnt, NPIX);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    fifo_in_empty = 1'b1; fifo_out_full = 1'b0; fifo_in_dout = 8'h00;
    test_reset();
    test_normal_frame();
    test_stall();
    test_abort();
    test_ignored_controls();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
